// File: rtl/ball_hit_pkg.sv
// Shared constants, FSM state type and saturating arithmetic for the ball-hit path.
package ball_hit_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned XY_W     = $clog2(H_TOTAL > V_TOTAL ? H_TOTAL : V_TOTAL);
  localparam int unsigned STREAK_W = 4;

  typedef enum logic [2:0] {
    WAIT_SOF,
    ACCUM,
    EVAL,
    REPORT,
    COOLDOWN
  } hit_state_t;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
    return (a == '1) ? a : a + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ball_window_counter.sv
// Latches the ball centre at SOF and counts target pixels in the square window,
// split into left/right halves with saturating counters.
module ball_window_counter
  import ball_hit_pkg::*;
#(
  parameter int unsigned BALL_HALF = 8
) (
  input  logic        clk_25MHz,
  input  logic        reset,
  input  logic        count_en,
  input  logic        sof,
  input  logic [9:0]  x_pixel,
  input  logic [9:0]  y_pixel,
  input  logic        is_target_color,
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  output logic [15:0] left_cnt,
  output logic [15:0] right_cnt,
  output logic [15:0] total_c
);

  localparam logic signed [10:0] HALF_S = 11'(BALL_HALF);

  logic [9:0] bx_q, by_q;
  logic [9:0] bx, by;
  logic signed [10:0] dx, dy;
  logic active, in_win, hit_px, is_left;

  // The SOF pixel itself belongs to the new frame, so it uses the incoming centre.
  assign bx = sof ? ball_x : bx_q;
  assign by = sof ? ball_y : by_q;

  assign dx = $signed({1'b0, x_pixel}) - $signed({1'b0, bx});
  assign dy = $signed({1'b0, y_pixel}) - $signed({1'b0, by});

  assign active  = (x_pixel < XY_W'(H_ACTIVE)) && (y_pixel < XY_W'(V_ACTIVE));
  assign in_win  = (dx <= HALF_S) && (dx >= -HALF_S) && (dy <= HALF_S) && (dy >= -HALF_S);
  assign hit_px  = active && in_win && is_target_color;
  assign is_left = x_pixel < bx;

  assign total_c = sat_add(left_cnt, right_cnt);

  always_ff @(posedge clk_25MHz) begin
    if (!reset) begin
      bx_q      <= '0;
      by_q      <= '0;
      left_cnt  <= '0;
      right_cnt <= '0;
    end else if (sof) begin
      bx_q      <= ball_x;
      by_q      <= ball_y;
      left_cnt  <= CNT_W'(hit_px && is_left);
      right_cnt <= CNT_W'(hit_px && !is_left);
    end else if (count_en && hit_px) begin
      if (is_left) left_cnt  <= sat_inc(left_cnt);
      else         right_cnt <= sat_inc(right_cnt);
    end
  end

endmodule

// File: rtl/ball_hit_frame_evaluator.sv
// Per-frame hit evaluator: confirms THRESHOLD over consecutive frames, reports the
// hit over valid/ready, then ignores a number of frame ends as cooldown.
module ball_hit_frame_evaluator
  import ball_hit_pkg::*;
#(
  parameter int unsigned THRESHOLD       = 50,
  parameter int unsigned BALL_HALF       = 8,
  parameter int unsigned CONFIRM_FRAMES  = 2,
  parameter int unsigned COOLDOWN_FRAMES = 3
) (
  input  logic        clk_25MHz,
  input  logic        reset,
  input  logic [9:0]  x_pixel,
  input  logic [9:0]  y_pixel,
  input  logic        is_target_color,
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  input  logic        hit_ready,
  output logic        hit_valid,
  output logic [15:0] hit_count,
  output logic        hit_dir,
  output logic [15:0] last_frame_count,
  output logic        cooldown_active
);

  hit_state_t          state;
  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streak_nxt;
  logic [STREAK_W-1:0] cd_cnt;
  logic                sof, eof;
  logic [15:0]         left_cnt, right_cnt, total_c;

  assign sof = (x_pixel == '0) && (y_pixel == '0);
  assign eof = (x_pixel == '0) && (y_pixel == XY_W'(V_ACTIVE));

  assign streak_nxt = (total_c >= CNT_W'(THRESHOLD)) ? streak + STREAK_W'(1) : '0;

  ball_window_counter #(
    .BALL_HALF(BALL_HALF)
  ) u_window (
    .clk_25MHz       (clk_25MHz),
    .reset           (reset),
    .count_en        (state != WAIT_SOF),
    .sof             (sof),
    .x_pixel         (x_pixel),
    .y_pixel         (y_pixel),
    .is_target_color (is_target_color),
    .ball_x          (ball_x),
    .ball_y          (ball_y),
    .left_cnt        (left_cnt),
    .right_cnt       (right_cnt),
    .total_c         (total_c)
  );

  always_ff @(posedge clk_25MHz) begin
    if (!reset) begin
      state            <= WAIT_SOF;
      streak           <= '0;
      cd_cnt           <= '0;
      hit_valid        <= 1'b0;
      hit_count        <= '0;
      hit_dir          <= 1'b0;
      last_frame_count <= '0;
      cooldown_active  <= 1'b0;
    end else begin
      case (state)
        WAIT_SOF: if (sof) state <= ACCUM;
        ACCUM:    if (eof) state <= EVAL;
        EVAL: begin
          last_frame_count <= total_c;
          if (streak_nxt == STREAK_W'(CONFIRM_FRAMES)) begin
            hit_count <= total_c;
            hit_dir   <= right_cnt > left_cnt;
            hit_valid <= 1'b1;
            streak    <= '0;
            state     <= REPORT;
          end else begin
            streak <= streak_nxt;
            state  <= ACCUM;
          end
        end
        REPORT: begin
          // Frame ends here only refresh the statistic; they never feed the streak.
          if (eof) last_frame_count <= total_c;
          if (hit_ready) begin
            hit_valid <= 1'b0;
            if (COOLDOWN_FRAMES == 0) begin
              state <= ACCUM;
            end else begin
              cd_cnt          <= STREAK_W'(COOLDOWN_FRAMES);
              cooldown_active <= 1'b1;
              state           <= COOLDOWN;
            end
          end
        end
        COOLDOWN: begin
          if (eof) begin
            last_frame_count <= total_c;
            if (cd_cnt <= STREAK_W'(1)) begin
              cd_cnt          <= '0;
              cooldown_active <= 1'b0;
              state           <= ACCUM;
            end else begin
              cd_cnt <= cd_cnt - STREAK_W'(1);
            end
          end
        end
        default: state <= WAIT_SOF;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_hit_frame_evaluator.sv
// Bench for ball_hit_frame_evaluator: compressed frames (SOF, window pixels, EOF)
// from a frame table plus hand-written handshake, reset and saturation sequences.
module tb_ball_hit_frame_evaluator;

  localparam int HALF   = 8;
  localparam int K_ALL  = 0;
  localparam int K_LEFT = 1;
  localparam int K_CNT  = 2;

  logic        clk_25MHz = 1'b0;
  logic        reset;
  logic [9:0]  x_pixel, y_pixel, ball_x, ball_y;
  logic        is_target_color, hit_ready;
  logic        hit_valid, hit_dir, cooldown_active;
  logic [15:0] hit_count, last_frame_count;

  typedef struct {
    int bx;
    int by;
    int kind;
    int n;
    int exp_last;
    bit exp_hit;
    bit exp_dir;
    bit exp_cd;
  } vec_t;

  typedef struct packed {
    logic [15:0] cnt;
    logic        dir;
  } hit_exp_t;

  vec_t     tbl[17];
  hit_exp_t hq[$];
  int       lq[$];
  int       n_checks = 0;
  int       n_fail   = 0;

  ball_hit_frame_evaluator #(
    .THRESHOLD(50), .BALL_HALF(HALF), .CONFIRM_FRAMES(2), .COOLDOWN_FRAMES(3)
  ) dut (
    .clk_25MHz        (clk_25MHz),
    .reset            (reset),
    .x_pixel          (x_pixel),
    .y_pixel          (y_pixel),
    .is_target_color  (is_target_color),
    .ball_x           (ball_x),
    .ball_y           (ball_y),
    .hit_ready        (hit_ready),
    .hit_valid        (hit_valid),
    .hit_count        (hit_count),
    .hit_dir          (hit_dir),
    .last_frame_count (last_frame_count),
    .cooldown_active  (cooldown_active)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic put(input int x, input int y, input bit t);
    x_pixel         = 10'(x);
    y_pixel         = 10'(y);
    is_target_color = t;
    @(posedge clk_25MHz);
    #1;
  endtask

  function automatic vec_t mk(input int bx, input int by, input int kind, input int n,
                              input int last, input bit hit, input bit dir, input bit cd);
    vec_t v;
    v.bx = bx; v.by = by; v.kind = kind; v.n = n;
    v.exp_last = last; v.exp_hit = hit; v.exp_dir = dir; v.exp_cd = cd;
    return v;
  endfunction

  // One compressed frame: SOF, the window plus a 1-pixel border, optional far pixels, EOF.
  task automatic drive_frame(input int bx, input int by, input int kind, input int n,
                             input int exp_last, input bit exp_hit, input bit check_lat);
    int cnt;
    bit t, inwin;
    lq.push_back(exp_last);
    ball_x = 10'(bx);
    ball_y = 10'(by);
    put(0, 0, kind == K_ALL);
    ball_x = 10'(bx + 37);
    ball_y = 10'(by + 23);
    cnt = 0;
    for (int yy = by - HALF - 1; yy <= by + HALF + 1; yy++) begin
      for (int xx = bx - HALF - 1; xx <= bx + HALF + 1; xx++) begin
        if (xx < 0 || yy < 0 || (xx == 0 && yy == 0)) continue;
        inwin = (xx >= bx - HALF) && (xx <= bx + HALF) && (yy >= by - HALF) && (yy <= by + HALF);
        case (kind)
          K_ALL:  t = 1'b1;
          K_LEFT: t = xx < bx;
          default: begin
            t = !inwin || (cnt < n);
            if (inwin && t) cnt++;
          end
        endcase
        put(xx, yy, t);
      end
    end
    if (kind == K_ALL) begin
      put(799, 0, 1); put(795, 6, 1); put(4, 524, 1); put(3, 500, 1);
    end
    put(0, 480, 1);
    if (check_lat) chk("valid_during_eval", hit_valid, 0);
    put(1, 480, 0);
    chk("last_frame_count", last_frame_count, lq.pop_front());
    if (check_lat) chk("valid_latency", hit_valid, exp_hit);
    put(2, 480, 0);
    if (check_lat && exp_hit && hit_ready) chk("valid_one_cycle", hit_valid, 0);
    put(3, 480, 0);
  endtask

  initial begin
    hit_exp_t e;

    // Transfer monitor: every accepted report is matched against the scoreboard.
    fork
      forever begin
        @(negedge clk_25MHz);
        if (reset && hit_valid && hit_ready) begin
          if (hq.size() == 0) begin
            chk("unexpected_hit", 1, 0);
          end else begin
            e = hq.pop_front();
            chk("hit_count", hit_count, e.cnt);
            chk("hit_dir", hit_dir, e.dir);
          end
        end
      end
    join_none

    tbl[0]  = mk(320, 240, K_ALL,  0, 289, 0, 0, 0);
    tbl[1]  = mk(320, 240, K_ALL,  0, 289, 1, 1, 0);
    tbl[2]  = mk(320, 240, K_ALL,  0, 289, 0, 0, 1);
    tbl[3]  = mk(320, 240, K_ALL,  0, 289, 0, 0, 1);
    tbl[4]  = mk(320, 240, K_ALL,  0, 289, 0, 0, 1);
    tbl[5]  = mk(320, 240, K_CNT, 60,  60, 0, 0, 0);
    tbl[6]  = mk(320, 240, K_CNT, 40,  40, 0, 0, 0);
    tbl[7]  = mk(320, 240, K_CNT, 60,  60, 0, 0, 0);
    tbl[8]  = mk(320, 240, K_CNT, 60,  60, 1, 0, 0);
    tbl[9]  = mk(320, 240, K_LEFT, 0, 136, 0, 0, 1);
    tbl[10] = mk(320, 240, K_LEFT, 0, 136, 0, 0, 1);
    tbl[11] = mk(320, 240, K_LEFT, 0, 136, 0, 0, 1);
    tbl[12] = mk(320, 240, K_LEFT, 0, 136, 0, 0, 0);
    tbl[13] = mk(320, 240, K_LEFT, 0, 136, 1, 0, 0);
    tbl[14] = mk(2,   2,   K_ALL,  0, 121, 0, 0, 1);
    tbl[15] = mk(2,   2,   K_ALL,  0, 121, 0, 0, 1);
    tbl[16] = mk(2,   2,   K_ALL,  0, 121, 0, 0, 1);

    reset = 1'b0; hit_ready = 1'b0; is_target_color = 1'b0;
    x_pixel = 10'd5; y_pixel = 10'd5; ball_x = 10'd320; ball_y = 10'd240;
    repeat (3) put(5, 5, 0);
    chk("rst_hit_valid", hit_valid, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_hit_dir", hit_dir, 0);
    chk("rst_last_frame_count", last_frame_count, 0);
    chk("rst_cooldown_active", cooldown_active, 0);
    reset = 1'b1;

    // Start mid-frame: pixels and frame ends without a SOF must never be evaluated.
    for (int k = 0; k < 2; k++) begin
      for (int xx = 300; xx < 340; xx++) put(xx, 200, 1);
      for (int yy = 1; yy <= 8; yy++)
        for (int xx = 1; xx <= 8; xx++) put(xx, yy, 1);
      put(0, 480, 1); put(1, 480, 0); put(2, 480, 0);
      chk("nosof_last_frame_count", last_frame_count, 0);
      chk("nosof_hit_valid", hit_valid, 0);
    end

    hit_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      chk("cooldown_at_frame_start", cooldown_active, tbl[i].exp_cd);
      if (tbl[i].exp_hit) hq.push_back({16'(tbl[i].exp_last), tbl[i].exp_dir});
      drive_frame(tbl[i].bx, tbl[i].by, tbl[i].kind, tbl[i].n, tbl[i].exp_last,
                  tbl[i].exp_hit, 1);
    end

    // Held report with backpressure, then exactly three cooldown frame ends.
    hit_ready = 1'b0;
    drive_frame(320, 240, K_ALL, 0, 289, 0, 1);
    hq.push_back({16'd289, 1'b1});
    drive_frame(320, 240, K_ALL, 0, 289, 1, 1);
    for (int k = 0; k < 3; k++) begin
      drive_frame(320, 240, K_CNT, 60, 60, 0, 0);
      chk("held_hit_valid", hit_valid, 1);
      chk("held_hit_count", hit_count, 289);
      chk("held_hit_dir", hit_dir, 1);
    end
    hit_ready = 1'b1;
    put(4, 480, 0);
    chk("ack_hit_valid", hit_valid, 0);
    chk("ack_cooldown_active", cooldown_active, 1);
    for (int k = 0; k < 3; k++) begin
      drive_frame(320, 240, K_ALL, 0, 289, 0, 1);
      chk("cooldown_after_eof", cooldown_active, k < 2);
    end

    // Reset while a report is pending drops it without a transfer.
    hit_ready = 1'b0;
    drive_frame(320, 240, K_ALL, 0, 289, 0, 1);
    drive_frame(320, 240, K_ALL, 0, 289, 1, 1);
    chk("pending_hit_valid", hit_valid, 1);
    reset = 1'b0;
    put(5, 480, 0);
    chk("rst_report_hit_valid", hit_valid, 0);
    chk("rst_report_hit_count", hit_count, 0);
    chk("rst_report_last", last_frame_count, 0);
    reset = 1'b1;
    hit_ready = 1'b1;

    // Saturation: right half pinned past 16 bits, then one left pixel on top.
    ball_x = 10'd320; ball_y = 10'd240;
    put(0, 0, 0);
    for (int k = 0; k < 65540; k++) put(320, 240, 1);
    put(319, 240, 1);
    put(0, 480, 1);
    put(1, 480, 0);
    chk("saturated_last_frame_count", last_frame_count, 65535);
    chk("saturated_hit_valid", hit_valid, 0);

    put(2, 480, 0);
    chk("hit_queue_empty", hq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
